// File: rtl/multi_cycle_processor.sv
// rtl/multi_cycle_processor.sv - multi-cycle RV-style integer core, FETCH/DECODE/EXECUTE/WRITEBACK FSM
// Optional retired-instruction counter and port: define MCP_PERF_CNT_EN.
module multi_cycle_processor #(
    parameter int              XLEN      = 32,
    parameter int              REG_COUNT = 32,
    parameter logic [XLEN-1:0] PC_RESET  = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            komut_req,
    output logic [XLEN-1:0] pc,
    input  logic [31:0]     komut,
    input  logic            komut_valid,
    output logic            hata
`ifdef MCP_PERF_CNT_EN
    ,
    output logic [31:0]     retired
`endif
);
    localparam int RW = $clog2(REG_COUNT);
    localparam int SW = $clog2(XLEN);

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WB,
        S_HATA
    } state_t;

    state_t          state;
    logic [31:0]     ir;
    logic [XLEN-1:0] rf [REG_COUNT];
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] npc;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [3:0] func;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign func   = {ir[30], ir[14:12]};

    assign komut_req = reset && (state == S_FETCH);
    assign hata      = (state == S_HATA);

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [XLEN-1:0] read_reg(input logic [4:0] idx);
        if (idx == 5'd0 || 32'(idx) >= REG_COUNT)
            return '0;
        return rf[idx[RW-1:0]];
    endfunction

    logic [XLEN-1:0] imm;
    logic            op_ok;
    logic            uses_rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            reg_err;

    always_comb begin
        imm      = '0;
        op_ok    = 1'b0;
        uses_rd  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_REG: begin
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                case (func)
                    4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                    4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: op_ok = 1'b1;
                    default: op_ok = 1'b0;
                endcase
            end
            OP_IMM: begin
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
                imm      = sext({{20{ir[31]}}, ir[31:20]});
                // bit 30 only selects an operation for the shifts; SLLI has no arithmetic form
                op_ok    = !(func == 4'b1001);
            end
            OP_LUI: begin
                uses_rd = 1'b1;
                imm     = sext({ir[31:12], 12'b0});
                op_ok   = 1'b1;
            end
            OP_JAL: begin
                uses_rd = 1'b1;
                imm     = sext({{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});
                op_ok   = 1'b1;
            end
            OP_BR: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm      = sext({{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
                op_ok    = (ir[14:13] == 2'b00);
            end
            default: op_ok = 1'b0;
        endcase
        reg_err = (uses_rd  && 32'(rd)  >= REG_COUNT) ||
                  (uses_rs1 && 32'(rs1) >= REG_COUNT) ||
                  (uses_rs2 && 32'(rs2) >= REG_COUNT);
    end

    logic [XLEN-1:0] b_val;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] alu;
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_pc;
    logic            exec_err;

    always_comb begin
        b_val = (opcode == OP_REG) ? op_b : imm;
        shamt = b_val[SW-1:0];
        alu   = '0;
        case (opcode)
            OP_REG, OP_IMM: begin
                case (func[2:0])
                    3'b000:  alu = (opcode == OP_REG && func[3]) ? op_a - b_val : op_a + b_val;
                    3'b001:  alu = op_a << shamt;
                    3'b010:  alu = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(b_val)};
                    3'b011:  alu = {{(XLEN-1){1'b0}}, op_a < b_val};
                    3'b100:  alu = op_a ^ b_val;
                    3'b101:  alu = func[3] ? XLEN'($signed(op_a) >>> shamt) : op_a >> shamt;
                    3'b110:  alu = op_a | b_val;
                    default: alu = op_a & b_val;
                endcase
            end
            OP_LUI:  alu = imm;
            OP_JAL:  alu = pc + XLEN'(4);
            default: alu = '0;
        endcase
        taken    = (opcode == OP_JAL) ||
                   (opcode == OP_BR && (ir[12] ? (op_a != op_b) : (op_a == op_b)));
        target   = pc + imm;
        next_pc  = taken ? target : pc + XLEN'(4);
        exec_err = !op_ok || reg_err || (taken && target[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_FETCH;
            pc     <= PC_RESET;
            ir     <= '0;
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
            npc    <= '0;
            for (int i = 0; i < REG_COUNT; i++)
                rf[i] <= '0;
`ifdef MCP_PERF_CNT_EN
            retired <= '0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    if (komut_valid) begin
                        ir    <= komut;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    op_a  <= read_reg(rs1);
                    op_b  <= read_reg(rs2);
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (exec_err) begin
                        state <= S_HATA;
                    end else begin
                        result <= alu;
                        npc    <= next_pc;
                        state  <= S_WB;
                    end
                end
                S_WB: begin
                    if (uses_rd && rd != 5'd0)
                        rf[rd[RW-1:0]] <= result;
                    pc    <= npc;
`ifdef MCP_PERF_CNT_EN
                    retired <= retired + 32'd1;
`endif
                    state <= S_FETCH;
                end
                default: state <= S_HATA;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_cycle_processor.sv
// tb/tb_multi_cycle_processor.sv - table-driven scoreboard bench for multi_cycle_processor
// Unit 0: XLEN=32/REG_COUNT=32/PC_RESET=0; unit 1: XLEN=64/REG_COUNT=16/PC_RESET=0x100.
module tb_multi_cycle_processor;
    logic        clk;
    logic        reset;
    logic [31:0] komut;
    logic        valid_a;
    logic        valid_b;
    logic        req_a;
    logic        req_b;
    logic        hata_a;
    logic        hata_b;
    logic [31:0] pc_a;
    logic [63:0] pc_b;
`ifdef MCP_PERF_CNT_EN
    logic [31:0] retired_a;
    logic [31:0] retired_b;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    multi_cycle_processor #(.XLEN(32), .REG_COUNT(32), .PC_RESET(32'h0)) dut_a (
        .clk(clk), .reset(reset), .komut_req(req_a), .pc(pc_a), .komut(komut),
        .komut_valid(valid_a), .hata(hata_a)
`ifdef MCP_PERF_CNT_EN
        , .retired(retired_a)
`endif
    );

    multi_cycle_processor #(.XLEN(64), .REG_COUNT(16), .PC_RESET(64'h100)) dut_b (
        .clk(clk), .reset(reset), .komut_req(req_b), .pc(pc_b), .komut(komut),
        .komut_valid(valid_b), .hata(hata_b)
`ifdef MCP_PERF_CNT_EN
        , .retired(retired_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          unit;
        logic [31:0] ins;
        int          waits;
        logic [63:0] exp_pc;
        int          ridx;
        logic [63:0] rval;
        logic        exp_hata;
        int          exp_lat;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_u(input int imm, input int rd);
        return {imm[19:0], rd[4:0], 7'b0110111};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic vec_t mk(input int unit, input logic [31:0] ins, input int waits,
                                input logic [63:0] exp_pc, input int ridx, input logic [63:0] rval,
                                input logic h);
        vec_t v;
        v.unit     = unit;
        v.ins      = ins;
        v.waits    = waits;
        v.exp_pc   = exp_pc;
        v.ridx     = ridx;
        v.rval     = rval;
        v.exp_hata = h;
        v.exp_lat  = (h ? 3 : 4) + waits;
        return v;
    endfunction

    function automatic logic [63:0] cur_pc(input int unit);
        return (unit != 0) ? pc_b : {32'b0, pc_a};
    endfunction
    function automatic logic cur_req(input int unit);
        return (unit != 0) ? req_b : req_a;
    endfunction
    function automatic logic cur_hata(input int unit);
        return (unit != 0) ? hata_b : hata_a;
    endfunction
    function automatic logic [63:0] cur_reg(input int unit, input int idx);
        logic [4:0] i5;
        i5 = idx[4:0];
        return (unit != 0) ? dut_b.rf[i5[3:0]] : {32'b0, dut_a.rf[i5]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_valid(input int unit, input logic v);
        if (unit != 0) valid_b = v;
        else           valid_a = v;
    endtask

    // Called at a negedge while the selected unit sits in FETCH.
    task automatic run_vec(input vec_t v);
        vec_t        e;
        int          cycles;
        logic [63:0] pc0;
        sb.push_back(v);
        cycles = 0;
        pc0    = cur_pc(v.unit);
        komut  = 32'hFFFF_FFFF;
        set_valid(v.unit, 1'b0);
        for (int i = 0; i < v.waits; i++) begin
            @(posedge clk); @(negedge clk); cycles++;
            chk("wait_req", 64'(cur_req(v.unit)), 64'd1);
            chk("wait_pc", cur_pc(v.unit), pc0);
        end
        komut = v.ins;
        set_valid(v.unit, 1'b1);
        @(posedge clk); @(negedge clk); cycles++;
        komut = 32'hFFFF_FFFF;
        while (cycles < 40) begin
            @(posedge clk); @(negedge clk); cycles++;
            if (cur_req(v.unit) || cur_hata(v.unit)) break;
        end
        set_valid(v.unit, 1'b0);
        e = sb.pop_front();
        chk($sformatf("lat u%0d %h", e.unit, e.ins), 64'(cycles), 64'(e.exp_lat));
        chk($sformatf("pc u%0d %h", e.unit, e.ins), cur_pc(e.unit), e.exp_pc);
        chk($sformatf("hata u%0d %h", e.unit, e.ins), 64'(cur_hata(e.unit)), 64'(e.exp_hata));
        chk($sformatf("req u%0d %h", e.unit, e.ins), 64'(cur_req(e.unit)), 64'(!e.exp_hata));
        chk($sformatf("x%0d u%0d %h", e.ridx, e.unit, e.ins), cur_reg(e.unit, e.ridx), e.rval);
    endtask

    task automatic do_reset();
        valid_a = 1'b0;
        valid_b = 1'b0;
        reset   = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_req_a", 64'(req_a), 64'd0);
        chk("rst_req_b", 64'(req_b), 64'd0);
        chk("rst_hata_a", 64'(hata_a), 64'd0);
        chk("rst_hata_b", 64'(hata_b), 64'd0);
        chk("rst_pc_a", 64'(pc_a), 64'h0);
        chk("rst_pc_b", pc_b, 64'h100);
        chk("rst_x1_a", cur_reg(0, 1), 64'd0);
`ifdef MCP_PERF_CNT_EN
        chk("rst_retired_a", 64'(retired_a), 64'd0);
`endif
        reset = 1'b1;
        #1;
        chk("c1_req_a", 64'(req_a), 64'd1);
        chk("c1_req_b", 64'(req_b), 64'd1);
        chk("c1_pc_a", 64'(pc_a), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        komut   = 32'h0;
        reset   = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;

        tbl.push_back(mk(0, enc_i(5, 0, 0, 1),          0, 64'h04, 1,  64'd5, 0));
        tbl.push_back(mk(0, enc_r(0, 1, 1, 0, 2),       0, 64'h08, 2,  64'd10, 0));
        tbl.push_back(mk(0, enc_i(-3, 0, 0, 3),         3, 64'h0C, 3,  64'hFFFF_FFFD, 0));
        tbl.push_back(mk(0, enc_r(32, 3, 1, 0, 4),      1, 64'h10, 4,  64'd8, 0));
        tbl.push_back(mk(0, enc_b(-8, 0, 0, 0),         0, 64'h08, 4,  64'd8, 0));
        tbl.push_back(mk(0, enc_b(-8, 0, 0, 1),         0, 64'h0C, 4,  64'd8, 0));
        tbl.push_back(mk(0, enc_i(12'h401, 3, 5, 5),    0, 64'h10, 5,  64'hFFFF_FFFE, 0));
        tbl.push_back(mk(0, enc_r(0, 1, 3, 2, 6),       0, 64'h14, 6,  64'd1, 0));
        tbl.push_back(mk(0, enc_r(0, 1, 3, 3, 7),       0, 64'h18, 7,  64'd0, 0));
        tbl.push_back(mk(0, enc_i(-1, 1, 4, 8),         0, 64'h1C, 8,  64'hFFFF_FFFA, 0));
        tbl.push_back(mk(0, enc_r(0, 2, 1, 1, 9),       0, 64'h20, 9,  64'h1400, 0));
        tbl.push_back(mk(0, enc_j(12, 1),               2, 64'h2C, 1,  64'h24, 0));
        tbl.push_back(mk(0, enc_u(20'h80000, 10),       0, 64'h30, 10, 64'h8000_0000, 0));
        tbl.push_back(mk(0, enc_i(7, 0, 0, 0),          0, 64'h34, 0,  64'd0, 0));
        tbl.push_back(mk(0, enc_r(0, 2, 10, 5, 11),     0, 64'h38, 11, 64'h0020_0000, 0));
        tbl.push_back(mk(0, enc_i(12'h100, 1, 6, 12),   0, 64'h3C, 12, 64'h124, 0));
        tbl.push_back(mk(0, enc_r(0, 9, 3, 7, 13),      0, 64'h40, 13, 64'h1400, 0));
        tbl.push_back(mk(0, enc_b(8, 2, 1, 1),          0, 64'h48, 13, 64'h1400, 0));
        tbl.push_back(mk(0, enc_b(8, 2, 1, 0),          0, 64'h4C, 13, 64'h1400, 0));
        tbl.push_back(mk(0, enc_i(12'h025, 1, 3, 14),   0, 64'h50, 14, 64'd1, 0));
        tbl.push_back(mk(0, enc_r(32, 2, 10, 5, 15),    0, 64'h54, 15, 64'hFFE0_0000, 0));
        tbl.push_back(mk(0, enc_i(12'h0F0, 3, 7, 16),   0, 64'h58, 16, 64'hF0, 0));
        tbl.push_back(mk(0, enc_j(2, 17),               1, 64'h58, 17, 64'd0, 1));
        tbl.push_back(mk(1, enc_i(-1, 0, 0, 1),         0, 64'h104, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0));
        tbl.push_back(mk(1, enc_i(12'h03F, 1, 1, 1),    0, 64'h108, 1, 64'h8000_0000_0000_0000, 0));
        tbl.push_back(mk(1, enc_i(12'h43F, 1, 5, 2),    2, 64'h10C, 2, 64'hFFFF_FFFF_FFFF_FFFF, 0));
        tbl.push_back(mk(1, enc_r(0, 2, 2, 0, 3),       0, 64'h110, 3, 64'hFFFF_FFFF_FFFF_FFFE, 0));
        tbl.push_back(mk(1, enc_u(20'h80000, 4),        0, 64'h114, 4, 64'hFFFF_FFFF_8000_0000, 0));
        tbl.push_back(mk(1, enc_j(-20, 5),              0, 64'h100, 5, 64'h118, 0));
        tbl.push_back(mk(1, enc_i(1, 0, 0, 20),         0, 64'h100, 5, 64'h118, 1));

        @(negedge clk);
        do_reset();
        foreach (tbl[i]) run_vec(tbl[i]);

        // Both units are now in HATA: fetch traffic must be ignored and pc frozen.
        komut   = enc_i(1, 0, 0, 1);
        valid_a = 1'b1;
        valid_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            chk("hold_hata_a", 64'(hata_a), 64'd1);
            chk("hold_req_a", 64'(req_a), 64'd0);
            chk("hold_pc_a", 64'(pc_a), 64'h58);
            chk("hold_hata_b", 64'(hata_b), 64'd1);
            chk("hold_pc_b", pc_b, 64'h100);
        end
        do_reset();

        run_vec(mk(0, 32'h0000_007F, 1, 64'h0, 1, 64'd0, 1));
        run_vec(mk(1, enc_r(32, 1, 1, 7, 3), 0, 64'h100, 3, 64'd0, 1));
        do_reset();

        run_vec(mk(0, enc_i(1, 0, 0, 1), 0, 64'h4, 1, 64'd1, 0));
        run_vec(mk(0, enc_i(1, 1, 0, 2), 0, 64'h8, 2, 64'd2, 0));
        run_vec(mk(0, enc_i(1, 2, 0, 3), 0, 64'hC, 3, 64'd3, 0));
`ifdef MCP_PERF_CNT_EN
        chk("retired_3", 64'(retired_a), 64'd3);
`endif
        // Reset landing in DECODE aborts the instruction.
        komut   = enc_i(9, 0, 0, 4);
        valid_a = 1'b1;
        @(posedge clk); @(negedge clk);
        valid_a = 1'b0;
        reset   = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("dec_rst_pc", 64'(pc_a), 64'h0);
        chk("dec_rst_x4", cur_reg(0, 4), 64'd0);
        chk("dec_rst_x3", cur_reg(0, 3), 64'd0);
        chk("dec_rst_req", 64'(req_a), 64'd0);
`ifdef MCP_PERF_CNT_EN
        chk("dec_rst_retired", 64'(retired_a), 64'd0);
`endif
        reset = 1'b1;
        #1;
        chk("dec_rst_c1_req", 64'(req_a), 64'd1);

        // Reset landing in WRITEBACK wins over the register and pc update.
        komut   = enc_i(3, 0, 0, 5);
        valid_a = 1'b1;
        @(posedge clk); @(negedge clk);
        valid_a = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("wb_pc_before", 64'(pc_a), 64'h0);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("wb_rst_x5", cur_reg(0, 5), 64'd0);
        chk("wb_rst_pc", 64'(pc_a), 64'h0);
        reset = 1'b1;
        #1;
        run_vec(mk(0, enc_i(6, 0, 0, 6), 0, 64'h4, 6, 64'd6, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_cycle_processor.md
# multi_cycle_processor

Parametrised multi-cycle successor to the team's single-cycle core: executes a RISC-V-style integer subset through a FETCH/DECODE/EXECUTE/WRITEBACK state machine. Instructions are fetched from an external memory over a request/valid handshake. The block is generalised in data width (XLEN) and register-file depth (REG_COUNT). Illegal instructions, out-of-range register indices and misaligned targets raise a sticky error.

## Interface
- XLEN, 32 — datapath, register and pc width; legal values 32 or 64.
- REG_COUNT, 32 — architectural registers; legal values 16 or 32. x0 is hardwired to zero.
- PC_RESET, 0 — pc value after reset; must be 4-byte aligned.
- clk  in  1  — single clock; all state updates on the rising edge.
- reset  in  1  — synchronous, active-low reset.
- komut_req  out  1  — fetch request; pc is valid while this is high.
- pc  out  XLEN  — address of the current instruction.
- komut  in  32  — instruction word; sampled when komut_req and komut_valid are both high.
- komut_valid  in  1  — memory response strobe.
- hata  out  1  — sticky error flag.
- retired  out  32  — retired-instruction count; port exists only with MCP_PERF_CNT_EN.

## Operation
- States: FETCH → DECODE → EXECUTE → WRITEBACK → FETCH. Any error goes to HATA, which is terminal until reset.
- FETCH:
  - komut_req=1.
  - Stays in FETCH while komut_valid=0.
  - When komut_valid=1, latches komut into the internal instruction register and goes to DECODE.
- DECODE:
  - Extracts opcode, rd, rs1, rs2 and func = {funct7[5], funct3}.
  - Reads rs1/rs2 and builds the sign-extended immediate (I/U/J/B formats, extended to XLEN).
- EXECUTE: computes the ALU result, branch decision and next pc.
- WRITEBACK: writes rd (when applicable), updates pc, increments retired.
- Supported instructions:
  - R-type (0110011): ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - I-type (0010011): ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI.
  - LUI (0110111).
  - JAL (1101111): rd ← pc+4.
  - BEQ, BNE (1100011).
- Arithmetic:
  - Modulo 2^XLEN.
  - Shift amount is the low log2(XLEN) bits.
  - LUI result is imm[31:12]<<12, sign-extended to XLEN.
- Next pc: pc+4 by default. Taken branch or JAL: pc+imm, wrapping modulo 2^XLEN.
- Writes with rd=0 are discarded. Reads of x0 return 0.
- Error conditions — the transition goes to HATA instead of WRITEBACK, and no register or pc update occurs:
  - unsupported opcode or func;
  - any used register index ≥ REG_COUNT;
  - taken-jump target with bits[1:0]≠0.
- In HATA: hata=1, komut_req=0, pc frozen, komut_valid ignored.

## Timing
- Reset values (reset=0 at a rising edge):
  - state=FETCH, pc=PC_RESET, komut_req=0 during reset, hata=0, all registers=0, retired=0.
- The first cycle with reset=1 asserts komut_req with pc=PC_RESET.
- Latency: 4 cycles per instruction when komut_valid is high in the first FETCH cycle. Each wait cycle adds 1.
- komut_valid outside FETCH is ignored. komut is never sampled in other states.
- pc and rd change at the same rising edge, the one ending WRITEBACK. The new pc is visible in the next FETCH cycle.
- hata rises at the edge ending EXECUTE of the faulting instruction.
- Reset asserted mid-instruction (any state): the instruction is aborted with no writeback, and all reset values apply at that edge.
- Reset has priority over every other event in the same cycle.

## Configuration
- MCP_PERF_CNT_EN defined:
  - Adds output `retired`, a 32-bit counter incremented at each WRITEBACK edge.
  - Wraps 0xFFFFFFFF→0.
  - Holds in HATA; cleared by reset.
- Undefined: no `retired` port and no counter logic; all other behaviour is identical.

## Test plan
- Reset, then komut_valid=1 constantly with ADDI x1,x0,5 then ADD x2,x1,x1 → x2=10, pc=PC_RESET+8 after 8 cycles, komut_req high in cycles 1 and 5.
- komut_valid delayed 3 cycles in FETCH → pc stable and komut_req held high, instruction latched only on the valid cycle, latency 7.
- BEQ x0,x0,-8 at pc=0x10 → pc=0x08. BNE x0,x0,-8 → pc=0x14. JAL x1,+12 at 0x20 → x1=0x24, pc=0x2C.
- ADDI x0,x0,7 → x0 still reads 0. With XLEN=64: SRAI of 0x8000_0000_0000_0000 by 63 → all ones.
- Opcode 0x7F, rd=20 with REG_COUNT=16, or JAL +2 → hata=1 one edge after EXECUTE, komut_req=0, pc frozen. Reset=0 → hata=0, pc=PC_RESET.
- With MCP_PERF_CNT_EN: 3 instructions → retired=3. Reset asserted in DECODE of the 4th → retired=0 and no writeback.
